// File: rtl/encoder_8_3_seq_if.sv
// Handshake bundle for the sequential 8-to-3 encoder.
// It carries the request-vector input side and the index-beat output side.
interface encoder_8_3_seq_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_vec;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_idx;
    logic       out_first;
    logic       out_last;
    logic       zero_drop;

    // The encoder itself uses the slave view; a source/sink pair uses the master view.
    modport slave (
        input  in_valid, in_vec, out_ready,
        output in_ready, out_valid, out_idx, out_first, out_last, zero_drop
    );

    modport master (
        output in_valid, in_vec, out_ready,
        input  in_ready, out_valid, out_idx, out_first, out_last, zero_drop
    );
endinterface

// File: rtl/encoder_8_3_seq.sv
// Sequential 8-to-3 encoder: takes a multi-hot vector and emits the index of every
// set bit, lowest first, one per output handshake; all-zero vectors are flagged and dropped.
module encoder_8_3_seq (
    input  logic               clk,
    input  logic               rst_n,
    encoder_8_3_seq_if.slave   bus
);

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t     state, state_next;
    logic [7:0] pending, pending_next;
    logic       first_flag, first_next;
    logic       zero_drop, zero_next;
    logic [2:0] idx;
    logic       last;

    // Lowest set bit wins: scan downward so the final hit is the smallest index.
    always_comb begin
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (pending[i]) idx = 3'(i);
        end
    end

    assign last = (pending != 8'd0) && ((pending & (pending - 8'd1)) == 8'd0);

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == EMIT);
    assign bus.out_idx   = idx;
    assign bus.out_first = first_flag;
    assign bus.out_last  = last;
    assign bus.zero_drop = zero_drop;

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path can infer a latch.
        state_next   = state;
        pending_next = pending;
        first_next   = first_flag;
        zero_next    = 1'b0;

        unique case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    if (bus.in_vec == 8'd0) begin
                        zero_next = 1'b1;
                    end else begin
                        pending_next = bus.in_vec;
                        first_next   = 1'b1;
                        state_next   = EMIT;
                    end
                end
            end
            EMIT: begin
                if (bus.out_ready) begin
                    pending_next = pending & ~(8'd1 << idx);
                    first_next   = 1'b0;
                    if (last) state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pending    <= 8'd0;
            first_flag <= 1'b0;
            zero_drop  <= 1'b0;
        end else begin
            // NOTE: non-blocking so all registers update from the same pre-edge values.
            state      <= state_next;
            pending    <= pending_next;
            first_flag <= first_next;
            zero_drop  <= zero_next;
        end
    end

endmodule

// File: tb/tb_encoder_8_3_seq.sv
// Self-checking bench for encoder_8_3_seq: directed steps followed by random vectors
// with random backpressure, compared against a bit-list reference model.
module tb_encoder_8_3_seq;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    encoder_8_3_seq_if bus ();

    encoder_8_3_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; outputs are sampled and inputs changed here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_in_ready"},  8'(bus.in_ready),  8'd1);
        check({tag, "_out_valid"}, 8'(bus.out_valid), 8'd0);
        check({tag, "_out_idx"},   8'(bus.out_idx),   8'd0);
        check({tag, "_out_first"}, 8'(bus.out_first), 8'd0);
        check({tag, "_out_last"},  8'(bus.out_last),  8'd0);
        check({tag, "_zero_drop"}, 8'(bus.zero_drop), 8'd0);
    endtask

    // Offer one vector, then drain its beats. hold = leading stall cycles,
    // rnd = random stalls afterwards, noise = keep in_valid high with 8'h01 during EMIT.
    task automatic run_vector(input logic [7:0] v, input int hold, input bit rnd, input bit noise);
        int q[$];
        int pos;
        int cyc;
        bit rdy;

        for (int i = 0; i < 8; i++) if (((v >> i) & 8'd1) != 8'd0) q.push_back(i);

        cyc = 0;
        while (!bus.in_ready && cyc < 20) begin
            step();
            cyc++;
        end
        check("ready_wait", 8'(bus.in_ready), 8'd1);

        bus.in_valid  = 1'b1;
        bus.in_vec    = v;
        bus.out_ready = 1'b0;
        step();
        if (noise) begin
            bus.in_vec = 8'h01;
        end else begin
            bus.in_valid = 1'b0;
            bus.in_vec   = $urandom_range(0, 255);
        end

        if (q.size() == 0) begin
            check("zero_pulse",     8'(bus.zero_drop), 8'd1);
            check("zero_no_valid",  8'(bus.out_valid), 8'd0);
            check("zero_in_ready",  8'(bus.in_ready),  8'd1);
            step();
            check("zero_pulse_end", 8'(bus.zero_drop), 8'd0);
            check("zero_no_valid2", 8'(bus.out_valid), 8'd0);
            return;
        end

        pos = 0;
        cyc = 0;
        while (pos < q.size() && cyc < 200) begin
            if (cyc < hold)  rdy = 1'b0;
            else if (rnd)    rdy = ($urandom_range(0, 3) != 0);
            else             rdy = 1'b1;
            bus.out_ready = rdy;
            check("beat_valid",    8'(bus.out_valid), 8'd1);
            check("beat_in_ready", 8'(bus.in_ready),  8'd0);
            check("beat_zero",     8'(bus.zero_drop), 8'd0);
            check("beat_idx",      8'(bus.out_idx),   8'(q[pos]));
            check("beat_first",    8'(bus.out_first), 8'(pos == 0));
            check("beat_last",     8'(bus.out_last),  8'(pos == q.size() - 1));
            step();
            if (rdy) pos++;
            cyc++;
        end
        check("beats_done", 8'(pos), 8'(q.size()));
        bus.out_ready = 1'b0;
        check("after_in_ready",  8'(bus.in_ready),  8'd1);
        check("after_out_valid", 8'(bus.out_valid), 8'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        bus.in_valid  = 1'b0;
        bus.in_vec    = 8'd0;
        bus.out_ready = 1'b0;
        rst_n = 1'b1;

        // Asynchronous reset applied mid-cycle.
        #3 rst_n = 1'b0;
        #1 check_idle_outputs("reset");
        repeat (2) step();
        rst_n = 1'b1;
        step();
        check_idle_outputs("post_reset");

        // Multi-bit vector, no stall: beats 1, 2, 5, 7.
        run_vector(8'b1010_0110, 0, 1'b0, 1'b0);

        // Backpressure: three stalled cycles hold index 0 with out_first.
        run_vector(8'h81, 3, 1'b0, 1'b0);

        // Back-to-back zero vectors, each giving its own pulse.
        bus.in_valid = 1'b1;
        bus.in_vec   = 8'h00;
        step();
        check("zero1_pulse", 8'(bus.zero_drop), 8'd1);
        check("zero1_valid", 8'(bus.out_valid), 8'd0);
        check("zero1_ready", 8'(bus.in_ready),  8'd1);
        step();
        check("zero2_pulse", 8'(bus.zero_drop), 8'd1);
        check("zero2_valid", 8'(bus.out_valid), 8'd0);
        bus.in_valid = 1'b0;
        step();
        check("zero2_end",   8'(bus.zero_drop), 8'd0);
        run_vector(8'h00, 0, 1'b0, 1'b0);

        // Single-bit vector.
        run_vector(8'h10, 0, 1'b0, 1'b0);

        // Full vector while in_valid stays high with 8'h01; that vector follows afterwards.
        run_vector(8'hFF, 0, 1'b0, 1'b1);
        run_vector(8'h01, 0, 1'b0, 1'b0);

        // Reset in the middle of emitting 8'hF0, after the index-4 beat.
        bus.in_valid = 1'b1;
        bus.in_vec   = 8'hF0;
        step();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        check("mid_idx4",   8'(bus.out_idx),   8'd4);
        check("mid_first4", 8'(bus.out_first), 8'd1);
        step();
        check("mid_idx5",   8'(bus.out_idx),   8'd5);
        #2 rst_n = 1'b0;
        #1 check_idle_outputs("mid_reset");
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("mid_no_beat", 8'(bus.out_valid), 8'd0);
        end
        bus.out_ready = 1'b0;
        run_vector(8'h02, 0, 1'b0, 1'b0);

        // Random vectors with random backpressure.
        for (int n = 0; n < 40; n++) begin
            run_vector(8'($urandom_range(0, 255)), $urandom_range(0, 2), 1'b1, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
